// File: rtl/gps_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gps_pkg: ASCII constants, gate FSM encoding and hex-digit decoder.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package gps_pkg;

    localparam logic [7:0] C_ASCII_DOLLAR = 8'h24;
    localparam logic [7:0] C_ASCII_STAR   = 8'h2A;
    localparam logic [7:0] C_ASCII_COMMA  = 8'h2C;

    localparam int unsigned C_STATE_W = 3;
    localparam logic [C_STATE_W-1:0] C_ST_IDLE  = 3'd0;
    localparam logic [C_STATE_W-1:0] C_ST_HDR   = 3'd1;
    localparam logic [C_STATE_W-1:0] C_ST_BODY  = 3'd2;
    localparam logic [C_STATE_W-1:0] C_ST_CK_HI = 3'd3;
    localparam logic [C_STATE_W-1:0] C_ST_CK_LO = 3'd4;
    localparam logic [C_STATE_W-1:0] C_ST_CHECK = 3'd5;
    localparam logic [C_STATE_W-1:0] C_ST_DRAIN = 3'd6;

    // Returns {ok, nibble}; only uppercase A-F are accepted as hex letters.
    function automatic logic [4:0] hex_nib(input logic [7:0] b);
        logic [4:0] r;
        r = 5'd0;
        if (b >= 8'h30 && b <= 8'h39) begin
            r = {1'b1, b[3:0]};
        end else if (b >= 8'h41 && b <= 8'h46) begin
            r = {1'b1, b[3:0] + 4'd9};
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nmea_line_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nmea_line_buf: single-port sentence store with registered read.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module nmea_line_buf #(
    parameter int unsigned DEPTH = 82,
    parameter int unsigned AW    = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Read data holds when rd_en is low, which keeps the output stable under stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= 8'd0;
        end else if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/nmea_sentence_gate.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nmea_sentence_gate: frames NMEA sentences, verifies checksum and     |
// | forwards matching sentences as a valid/ready byte stream.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module nmea_sentence_gate
    import gps_pkg::*;
#(
    parameter int unsigned MAX_LEN = 82,
    parameter logic [39:0] SEL_ID  = "GPGLL"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        err_cksum,
    output logic        err_len,
    output logic        err_frame,
    output logic [15:0] ok_cnt,
    output logic [15:0] drop_cnt
);

    localparam int unsigned AW = $clog2(MAX_LEN + 1);
    localparam logic [AW-1:0] C_MAX_PTR  = AW'(MAX_LEN);
    localparam logic [AW-1:0] C_HDR_LAST = AW'(5);

    logic [C_STATE_W-1:0] r_state, w_next_state;
    logic [AW-1:0] r_ptr, r_rd_idx;
    logic [7:0]    r_xor;
    logic [3:0]    r_ck_hi;
    logic          r_ck_match, r_out_valid, r_out_last;
    logic          r_err_len, r_err_frame, r_err_cksum;
    logic [15:0]   r_ok_cnt, r_drop_cnt;

    logic          w_is_dollar, w_is_star, w_hdr_match;
    logic [4:0]    w_hex;
    logic [7:0]    w_rcv;
    logic [39:0]   w_sel_shift;
    logic [2:0]    w_hdr_idx;
    logic          w_wr_en, w_rd_en, w_load, w_ok, w_drop;
    logic          w_err_len, w_err_frame, w_err_cksum;
    logic [AW-1:0] w_wr_addr, w_rd_addr;
    logic [7:0]    w_rd_data;

    assign w_is_dollar = (rx_data == C_ASCII_DOLLAR);
    assign w_is_star   = (rx_data == C_ASCII_STAR);
    assign w_hex       = hex_nib(rx_data);
    assign w_rcv       = {r_ck_hi, w_hex[3:0]};
    // ptr 1..5 selects ID characters 0..4, most significant byte first
    assign w_hdr_idx   = r_ptr[2:0] - 3'd1;
    assign w_sel_shift = SEL_ID << {w_hdr_idx, 3'b000};
    assign w_hdr_match = (rx_data == w_sel_shift[39:32]);
    assign w_load      = !r_out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            C_ST_IDLE:  if (rx_valid && w_is_dollar) w_next_state = C_ST_HDR;
            C_ST_HDR: begin
                if (rx_valid) begin
                    if (!w_hdr_match)             w_next_state = C_ST_IDLE;
                    else if (r_ptr == C_HDR_LAST) w_next_state = C_ST_BODY;
                end
            end
            C_ST_BODY: begin
                if (rx_valid) begin
                    if (w_is_star)                w_next_state = C_ST_CK_HI;
                    else if (w_is_dollar)         w_next_state = C_ST_HDR;
                    else if (r_ptr == C_MAX_PTR)  w_next_state = C_ST_IDLE;
                end
            end
            C_ST_CK_HI: if (rx_valid) w_next_state = w_hex[4] ? C_ST_CK_LO : C_ST_IDLE;
            C_ST_CK_LO: if (rx_valid) w_next_state = w_hex[4] ? C_ST_CHECK : C_ST_IDLE;
            C_ST_CHECK: w_next_state = r_ck_match ? C_ST_DRAIN : C_ST_IDLE;
            C_ST_DRAIN: if (r_out_valid && out_ready && r_out_last) w_next_state = C_ST_IDLE;
            default:    w_next_state = C_ST_IDLE;
        endcase
    end

    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_addr   = r_ptr;
        w_rd_en     = 1'b0;
        w_rd_addr   = r_rd_idx;
        w_err_len   = 1'b0;
        w_err_frame = 1'b0;
        w_err_cksum = 1'b0;
        w_drop      = 1'b0;
        w_ok        = 1'b0;
        case (r_state)
            C_ST_IDLE: begin
                w_wr_en   = rx_valid && w_is_dollar;
                w_wr_addr = '0;
            end
            C_ST_HDR:   w_wr_en = rx_valid;
            C_ST_BODY: begin
                if (rx_valid && w_is_dollar) begin
                    w_wr_en     = 1'b1;
                    w_wr_addr   = '0;
                    w_err_frame = 1'b1;
                    w_drop      = 1'b1;
                end else if (rx_valid && !w_is_star) begin
                    w_wr_en   = (r_ptr != C_MAX_PTR);
                    w_err_len = (r_ptr == C_MAX_PTR);
                    w_drop    = w_err_len;
                end
            end
            C_ST_CK_HI: begin
                w_err_cksum = rx_valid && !w_hex[4];
                w_drop      = w_err_cksum;
            end
            // A bad checksum is flagged at the CK_LO edge so the pulse lands in CHECK.
            C_ST_CK_LO: begin
                w_err_cksum = rx_valid && (!w_hex[4] || (w_rcv != r_xor));
                w_drop      = w_err_cksum;
            end
            C_ST_CHECK: begin
                w_ok      = r_ck_match;
                w_rd_en   = r_ck_match;
                w_rd_addr = '0;
            end
            C_ST_DRAIN: begin
                w_rd_en     = w_load && (r_rd_idx < r_ptr);
                w_err_frame = rx_valid;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_rd_idx    <= '0;
            r_xor       <= 8'd0;
            r_ck_hi     <= 4'd0;
            r_ck_match  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_err_len   <= 1'b0;
            r_err_frame <= 1'b0;
            r_err_cksum <= 1'b0;
            r_ok_cnt    <= 16'd0;
            r_drop_cnt  <= 16'd0;
        end else begin
            r_err_len   <= w_err_len;
            r_err_frame <= w_err_frame && !w_err_len;
            r_err_cksum <= w_err_cksum && !w_err_frame && !w_err_len;
            if (w_ok && r_ok_cnt != 16'hFFFF)     r_ok_cnt   <= r_ok_cnt + 16'd1;
            if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
            case (r_state)
                C_ST_IDLE: begin
                    if (rx_valid && w_is_dollar) begin
                        r_ptr <= AW'(1);
                        r_xor <= 8'd0;
                    end
                end
                C_ST_HDR: begin
                    if (rx_valid) begin
                        r_ptr <= r_ptr + AW'(1);
                        r_xor <= r_xor ^ rx_data;
                    end
                end
                C_ST_BODY: begin
                    if (rx_valid && w_is_dollar) begin
                        r_ptr <= AW'(1);
                        r_xor <= 8'd0;
                    end else if (rx_valid && !w_is_star && r_ptr != C_MAX_PTR) begin
                        r_ptr <= r_ptr + AW'(1);
                        r_xor <= r_xor ^ rx_data;
                    end
                end
                C_ST_CK_HI: if (rx_valid) r_ck_hi <= w_hex[3:0];
                C_ST_CK_LO: if (rx_valid) r_ck_match <= w_hex[4] && (w_rcv == r_xor);
                C_ST_CHECK: begin
                    r_rd_idx    <= AW'(1);
                    r_out_valid <= r_ck_match;
                    r_out_last  <= r_ck_match && (r_ptr == AW'(1));
                end
                C_ST_DRAIN: begin
                    if (w_load) begin
                        r_out_valid <= w_rd_en;
                        r_out_last  <= w_rd_en && (r_rd_idx == r_ptr - AW'(1));
                        if (w_rd_en) r_rd_idx <= r_rd_idx + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    nmea_line_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_line_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wr_en),
        .wr_addr (w_wr_addr),
        .wr_data (rx_data),
        .rd_en   (w_rd_en),
        .rd_addr (w_rd_addr),
        .rd_data (w_rd_data)
    );

    assign out_data  = w_rd_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign busy      = (r_state != C_ST_IDLE);
    assign err_cksum = r_err_cksum;
    assign err_len   = r_err_len;
    assign err_frame = r_err_frame;
    assign ok_cnt    = r_ok_cnt;
    assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_nmea_sentence_gate.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_nmea_sentence_gate: directed scenarios for the NMEA sentence gate.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_nmea_sentence_gate;

    logic        clk = 1'b0;
    logic        rst, rx_valid, out_ready;
    logic [7:0]  rx_data;
    logic [7:0]  out_data;
    logic        out_valid, out_last, busy, err_cksum, err_len, err_frame;
    logic [15:0] ok_cnt, drop_cnt;

    int passed = 0;
    int total  = 0;
    int exp_ok = 0;
    int exp_drop = 0;

    logic [7:0] q_data[$];
    bit         q_last[$];
    int n_ck, n_len, n_frame, n_ov, stall_viol;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'd0;

    localparam string S1 = "GPGLL,1548.1234,S,04715.5678,W";
    localparam string S2 = "GPGLL,4916.45,N,12311.12,W,225444,A";

    nmea_sentence_gate #(.MAX_LEN(82), .SEL_ID("GPGLL")) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .err_cksum(err_cksum),
        .err_len(err_len), .err_frame(err_frame), .ok_cnt(ok_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Observer: samples mid-cycle, after the bench has driven its inputs.
    always @(negedge clk) begin
        #2;
        if (out_valid && out_ready) begin
            q_data.push_back(out_data);
            q_last.push_back(out_last);
        end
        if (prev_stall && (!out_valid || out_data !== prev_data)) stall_viol++;
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        if (err_cksum) n_ck++;
        if (err_len)   n_len++;
        if (err_frame) n_frame++;
        if (out_valid) n_ov++;
    end

    function automatic logic [7:0] xsum(input string s);
        logic [7:0] x = 8'd0;
        for (int i = 0; i < s.len(); i++) x = x ^ s[i];
        return x;
    endfunction

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic send_sentence(input string body, input logic [7:0] ck);
        send_byte("$");
        send_str(body);
        send_byte("*");
        send_byte(hexc(ck[7:4]));
        send_byte(hexc(ck[3:0]));
    endtask

    task automatic clear_obs();
        q_data.delete();
        q_last.delete();
        n_ck = 0; n_len = 0; n_frame = 0; n_ov = 0; stall_viol = 0;
    endtask

    task automatic run_drain(input bit toggle, input int inject_at, output bit timed_out);
        timed_out = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            out_ready = toggle ? ~out_ready : 1'b1;
            if (k == inject_at) begin
                rx_data  = "$";
                rx_valid = 1'b1;
            end else begin
                rx_valid = 1'b0;
            end
            if (k > 2 && !busy) begin
                timed_out = 1'b0;
                break;
            end
        end
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'd0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
        total++; if (out_data !== 8'd0) $display("FAIL reset_out_data got %h want 00", out_data); else passed++;
        total++; if (out_last !== 1'b0) $display("FAIL reset_out_last got %b want 0", out_last); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        total++; if ({err_cksum, err_len, err_frame} !== 3'b000)
            $display("FAIL reset_errs got %b want 000", {err_cksum, err_len, err_frame}); else passed++;
        total++; if (ok_cnt !== 16'd0) $display("FAIL reset_ok_cnt got %0d want 0", ok_cnt); else passed++;
        total++; if (drop_cnt !== 16'd0) $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); else passed++;
    endtask

    task automatic test_good();
        string exp_s;
        int bad;
        bit to;
        clear_obs();
        exp_s = {"$", S1};
        send_sentence(S1, xsum(S1));
        total++; if (out_valid !== 1'b0) $display("FAIL good_check_cycle_valid got %b want 0", out_valid); else passed++;
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || out_data !== 8'h24)
            $display("FAIL good_first_latency got v=%b d=%h want v=1 d=24", out_valid, out_data); else passed++;
        run_drain(1'b0, -1, to);
        exp_ok++;
        total++; if (to) $display("FAIL good_drain_timeout got timeout want idle"); else passed++;
        bad = 0;
        for (int i = 0; i < q_data.size() && i < exp_s.len(); i++)
            if (q_data[i] !== exp_s[i] || q_last[i] !== (i == exp_s.len() - 1)) bad++;
        total++; if (q_data.size() != exp_s.len()) $display("FAIL good_len got %0d want %0d", q_data.size(), exp_s.len()); else passed++;
        total++; if (bad != 0) $display("FAIL good_bytes got %0d bad bytes want 0", bad); else passed++;
        total++; if (ok_cnt !== 16'(exp_ok)) $display("FAIL good_ok_cnt got %0d want %0d", ok_cnt, exp_ok); else passed++;
        total++; if (n_ck + n_len + n_frame != 0) $display("FAIL good_err_pulses got %0d want 0", n_ck + n_len + n_frame); else passed++;
    endtask

    task automatic test_bad_cksum();
        clear_obs();
        send_sentence(S1, xsum(S1) + 8'd1);
        total++; if (err_cksum !== 1'b1) $display("FAIL bad_ck_pulse_in_check got %b want 1", err_cksum); else passed++;
        repeat (5) @(negedge clk);
        exp_drop++;
        total++; if (n_ck != 1) $display("FAIL bad_ck_pulses got %0d want 1", n_ck); else passed++;
        total++; if (n_ov != 0) $display("FAIL bad_ck_out_valid got %0d cycles want 0", n_ov); else passed++;
        total++; if (drop_cnt !== 16'(exp_drop)) $display("FAIL bad_ck_drop_cnt got %0d want %0d", drop_cnt, exp_drop); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL bad_ck_busy got %b want 0", busy); else passed++;
    endtask

    task automatic test_foreign();
        logic [7:0] ck;
        clear_obs();
        ck = xsum("GPGGA,123519,4807.038,N");
        send_str("$GPG");
        total++; if (busy !== 1'b1) $display("FAIL foreign_busy_hdr got %b want 1", busy); else passed++;
        send_byte("G");
        total++; if (busy !== 1'b0) $display("FAIL foreign_idle_at_g got %b want 0", busy); else passed++;
        send_str("A,123519,4807.038,N*");
        send_byte(hexc(ck[7:4]));
        send_byte(hexc(ck[3:0]));
        repeat (4) @(negedge clk);
        total++; if (n_ov != 0) $display("FAIL foreign_out_valid got %0d want 0", n_ov); else passed++;
        total++; if (n_ck + n_len + n_frame != 0) $display("FAIL foreign_err_pulses got %0d want 0", n_ck + n_len + n_frame); else passed++;
        total++; if (ok_cnt !== 16'(exp_ok) || drop_cnt !== 16'(exp_drop))
            $display("FAIL foreign_counters got %0d/%0d want %0d/%0d", ok_cnt, drop_cnt, exp_ok, exp_drop); else passed++;
    endtask

    task automatic test_len();
        clear_obs();
        send_str("$GPGLL,");
        for (int i = 0; i < 75; i++) send_byte("1");
        total++; if (err_len !== 1'b0) $display("FAIL len_no_err_at_82 got %b want 0", err_len); else passed++;
        send_byte("1");
        total++; if (err_len !== 1'b1) $display("FAIL len_err_at_83 got %b want 1", err_len); else passed++;
        for (int i = 0; i < 14; i++) send_byte("1");
        repeat (3) @(negedge clk);
        exp_drop++;
        total++; if (n_len != 1) $display("FAIL len_pulses got %0d want 1", n_len); else passed++;
        total++; if (drop_cnt !== 16'(exp_drop)) $display("FAIL len_drop_cnt got %0d want %0d", drop_cnt, exp_drop); else passed++;
        total++; if (busy !== 1'b0 || n_ov != 0) $display("FAIL len_idle got busy=%b ov=%0d want 0/0", busy, n_ov); else passed++;
    endtask

    task automatic test_stall();
        string exp_s;
        int bad;
        bit to;
        clear_obs();
        exp_s = {"$", S1};
        send_sentence(S1, xsum(S1));
        run_drain(1'b1, 4, to);
        exp_ok++;
        total++; if (to) $display("FAIL stall_drain_timeout got timeout want idle"); else passed++;
        bad = 0;
        for (int i = 0; i < q_data.size() && i < exp_s.len(); i++)
            if (q_data[i] !== exp_s[i] || q_last[i] !== (i == exp_s.len() - 1)) bad++;
        total++; if (q_data.size() != exp_s.len()) $display("FAIL stall_len got %0d want %0d", q_data.size(), exp_s.len()); else passed++;
        total++; if (bad != 0) $display("FAIL stall_bytes got %0d bad bytes want 0", bad); else passed++;
        total++; if (stall_viol != 0) $display("FAIL stall_stability got %0d changes want 0", stall_viol); else passed++;
        total++; if (n_frame != 1) $display("FAIL stall_err_frame got %0d want 1", n_frame); else passed++;
        total++; if (drop_cnt !== 16'(exp_drop) || ok_cnt !== 16'(exp_ok))
            $display("FAIL stall_counters got %0d/%0d want %0d/%0d", ok_cnt, drop_cnt, exp_ok, exp_drop); else passed++;
    endtask

    task automatic test_back_to_back();
        string exp_s;
        int bad;
        bit to;
        clear_obs();
        exp_s = {"$", S2};
        send_str("$GPGLL,12");
        send_sentence(S2, xsum(S2));
        run_drain(1'b0, -1, to);
        exp_ok++;
        exp_drop++;
        total++; if (to) $display("FAIL b2b_drain_timeout got timeout want idle"); else passed++;
        total++; if (n_frame != 1) $display("FAIL b2b_err_frame got %0d want 1", n_frame); else passed++;
        bad = 0;
        for (int i = 0; i < q_data.size() && i < exp_s.len(); i++)
            if (q_data[i] !== exp_s[i] || q_last[i] !== (i == exp_s.len() - 1)) bad++;
        total++; if (q_data.size() != exp_s.len() || bad != 0)
            $display("FAIL b2b_stream got len=%0d bad=%0d want len=%0d bad=0", q_data.size(), bad, exp_s.len()); else passed++;
        total++; if (ok_cnt !== 16'(exp_ok) || drop_cnt !== 16'(exp_drop))
            $display("FAIL b2b_counters got %0d/%0d want %0d/%0d", ok_cnt, drop_cnt, exp_ok, exp_drop); else passed++;
    endtask

    task automatic test_rst_drain();
        clear_obs();
        out_ready = 1'b0;
        send_sentence(S1, xsum(S1));
        @(negedge clk);
        total++; if (out_valid !== 1'b1) $display("FAIL rstd_stalled_valid got %b want 1", out_valid); else passed++;
        rst = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL rstd_after_rst got v=%b busy=%b want 0/0", out_valid, busy); else passed++;
        total++; if (ok_cnt !== 16'd0 || drop_cnt !== 16'd0)
            $display("FAIL rstd_counters got %0d/%0d want 0/0", ok_cnt, drop_cnt); else passed++;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_good();
        test_bad_cksum();
        test_foreign();
        test_len();
        test_stall();
        test_back_to_back();
        test_rst_drain();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
